// File: rtl/microsequencer_store.sv
// Microsequencer with a writable control store.
// One micro-instruction executes per clock. Each microword carries a target
// address, a branch opcode (BOP) and a field of control bits. The sequencer
// supports conditional branches, a go-wait loop, opcode dispatch and a
// bounded subroutine stack with a sticky error flag.
module microsequencer_store #(
    parameter int AW = 8,
    parameter int DW = 24,
    parameter int SD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DW-1:0]        wdata,
    input  logic                 go_bar,
    input  logic [1:0]           cond,
    input  logic [3:0]           opcode,
    output logic [AW-1:0]        microaddress,
    output logic [DW-1:0]        microword,
    output logic [DW-AW-5:0]     control_bits,
    output logic                 halted,
    output logic                 stack_err
);

    localparam int DEPTH  = 1 << AW;
    localparam int SPW    = $clog2(SD + 1);
    // Stack storage is rounded up to a power of two so the pointer indexes it
    // without width adaptation; entries at or above SD are never written.
    localparam int SDEPTH = 1 << SPW;

    localparam logic [3:0] BOP_CONT = 4'b0000;
    localparam logic [3:0] BOP_JMP  = 4'b0001;
    localparam logic [3:0] BOP_BRC0 = 4'b0010;
    localparam logic [3:0] BOP_BRC1 = 4'b0011;
    localparam logic [3:0] BOP_WAIT = 4'b0100;
    localparam logic [3:0] BOP_CALL = 4'b0101;
    localparam logic [3:0] BOP_RET  = 4'b0110;
    localparam logic [3:0] BOP_DISP = 4'b0111;
    localparam logic [3:0] BOP_HALT = 4'b1000;

    localparam logic [SPW-1:0] SP_FULL  = SPW'(SD);
    localparam logic [SPW-1:0] SP_EMPTY = {SPW{1'b0}};

    // Elaboration-time parameter legality checks.
    if (AW < 5) begin : g_aw_chk
        $error("microsequencer_store: AW must be at least 5");
    end
    if (DW < AW + 5) begin : g_dw_chk
        $error("microsequencer_store: DW must be at least AW+5");
    end
    if ((SD < 1) || (SD > 16)) begin : g_sd_chk
        $error("microsequencer_store: SD must be in 1..16");
    end

    logic [DW-1:0]  mem_q   [0:DEPTH-1];
    logic [AW-1:0]  stack_q [0:SDEPTH-1];
    logic [AW-1:0]  upc_q,  upc_d;
    logic [SPW-1:0] sp_q,   sp_d;
    logic           err_q,  err_d;
    logic           push_s;

    logic [DW-1:0]  word_s;
    logic [3:0]     bop_s;
    logic [AW-1:0]  tgt_s;
    logic [AW-1:0]  upc_inc_s;
    logic [SPW-1:0] sp_m1_s;

    assign word_s    = mem_q[upc_q];
    assign bop_s     = word_s[AW+3:AW];
    assign tgt_s     = word_s[AW-1:0];
    assign upc_inc_s = upc_q + AW'(1'b1);
    assign sp_m1_s   = sp_q - SPW'(1'b1);

    // Control store write port; contents are not touched by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Next uPC, stack pointer and error flag from the current microword.
    always_comb begin
        upc_d  = upc_inc_s;
        sp_d   = sp_q;
        err_d  = err_q;
        push_s = 1'b0;
        case (bop_s)
            BOP_CONT: upc_d = upc_inc_s;
            BOP_JMP:  upc_d = tgt_s;
            BOP_BRC0: begin
                if (cond[0]) begin
                    upc_d = tgt_s;
                end else begin
                    upc_d = upc_inc_s;
                end
            end
            BOP_BRC1: begin
                if (cond[1]) begin
                    upc_d = tgt_s;
                end else begin
                    upc_d = upc_inc_s;
                end
            end
            BOP_WAIT: begin
                if (go_bar) begin
                    upc_d = tgt_s;
                end else begin
                    upc_d = upc_inc_s;
                end
            end
            BOP_CALL: begin
                if (sp_q == SP_FULL) begin
                    // Overflow: skip the call and flag it.
                    upc_d = upc_inc_s;
                    err_d = 1'b1;
                end else begin
                    push_s = 1'b1;
                    sp_d   = sp_q + SPW'(1'b1);
                    upc_d  = tgt_s;
                end
            end
            BOP_RET: begin
                if (sp_q == SP_EMPTY) begin
                    // Underflow: restart from address zero and flag it.
                    upc_d = {AW{1'b0}};
                    err_d = 1'b1;
                end else begin
                    sp_d  = sp_m1_s;
                    upc_d = stack_q[sp_m1_s];
                end
            end
            BOP_DISP: upc_d = {opcode, tgt_s[AW-5:0]};
            BOP_HALT: upc_d = upc_q;
            default:  upc_d = upc_inc_s;
        endcase
    end

    // Sequencer state registers; reset overrides whatever the BOP requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            upc_q <= {AW{1'b0}};
            sp_q  <= SP_EMPTY;
            err_q <= 1'b0;
        end else begin
            upc_q <= upc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Return-address storage; a push is dropped when reset wins the edge.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            stack_q[sp_q] <= upc_inc_s;
        end
    end

    assign microaddress = upc_q;
    assign microword    = word_s;
    assign control_bits = word_s[DW-1:AW+4];
    assign halted       = (bop_s == BOP_HALT);
    assign stack_err    = err_q;

endmodule

// File: tb/tb_microsequencer_store.sv
// Directed bench for microsequencer_store (AW=8, DW=24, SD=4).
// Each scenario loads a small micro-program while reset is held, releases
// reset and compares the uPC trace and flags against hand-computed values.
module tb_microsequencer_store;

    localparam logic [3:0] CONT = 4'b0000;
    localparam logic [3:0] JMP  = 4'b0001;
    localparam logic [3:0] BRC0 = 4'b0010;
    localparam logic [3:0] BRC1 = 4'b0011;
    localparam logic [3:0] WGO  = 4'b0100;
    localparam logic [3:0] CALL = 4'b0101;
    localparam logic [3:0] RET  = 4'b0110;
    localparam logic [3:0] DISP = 4'b0111;
    localparam logic [3:0] HALT = 4'b1000;

    logic        clk;
    logic        rst;
    logic        we;
    logic [7:0]  waddr;
    logic [23:0] wdata;
    logic        go_bar;
    logic [1:0]  cond;
    logic [3:0]  opcode;
    logic [7:0]  microaddress;
    logic [23:0] microword;
    logic [11:0] control_bits;
    logic        halted;
    logic        stack_err;

    int n_chk;
    int n_pass;

    microsequencer_store #(.AW(8), .DW(24), .SD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .go_bar       (go_bar),
        .cond         (cond),
        .opcode       (opcode),
        .microaddress (microaddress),
        .microword    (microword),
        .control_bits (control_bits),
        .halted       (halted),
        .stack_err    (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic [11:0] c, input logic [3:0] b, input logic [7:0] t);
        return {c, b, t};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [23:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we    = 1'b0;
    endtask

    logic [7:0] exp_pc  [0:10];
    logic       exp_err [0:10];

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        we     = 1'b0;
        waddr  = 8'h00;
        wdata  = 24'h000000;
        go_bar = 1'b1;
        cond   = 2'b00;
        opcode = 4'h3;
        step();

        // Scenario 1: jump, go-wait loop, dispatch.
        wr(8'h00, mk(12'h5A3, JMP,  8'h0C));
        wr(8'h0C, mk(12'h000, CONT, 8'h00));
        wr(8'h0D, mk(12'h000, WGO,  8'h0D));
        wr(8'h0E, mk(12'h000, DISP, 8'h01));
        wr(8'h31, mk(12'hC3F, HALT, 8'h00));
        step();
        check("rst_upc",   {24'd0, microaddress}, 32'h00);
        check("rst_err",   {31'd0, stack_err},    32'h0);
        check("rst_halt",  {31'd0, halted},       32'h0);
        check("rst_word",  {8'd0, microword},     32'h5A310C);
        check("rst_ctl",   {20'd0, control_bits}, 32'h5A3);
        rst = 1'b0;
        step();
        check("s1_jmp",    {24'd0, microaddress}, 32'h0C);
        step();
        check("s1_cont",   {24'd0, microaddress}, 32'h0D);
        step();
        check("s1_wait1",  {24'd0, microaddress}, 32'h0D);
        step();
        check("s1_wait2",  {24'd0, microaddress}, 32'h0D);
        go_bar = 1'b0;
        step();
        check("s1_go",     {24'd0, microaddress}, 32'h0E);
        step();
        check("s1_disp",   {24'd0, microaddress}, 32'h31);
        check("s1_halted", {31'd0, halted},       32'h1);
        check("s1_ctl",    {20'd0, control_bits}, 32'hC3F);
        step();
        check("s1_hold",   {24'd0, microaddress}, 32'h31);

        // Scenario 2: single call/return, then condition branches.
        rst  = 1'b1;
        cond = 2'b01;
        wr(8'h00, mk(12'h000, JMP,  8'h10));
        wr(8'h10, mk(12'h000, CALL, 8'h40));
        wr(8'h40, mk(12'h000, RET,  8'h00));
        wr(8'h11, mk(12'h000, BRC1, 8'h15));
        wr(8'h12, mk(12'h000, BRC0, 8'h30));
        wr(8'h30, mk(12'h000, HALT, 8'h00));
        rst = 1'b0;
        step();
        check("s2_pc10",   {24'd0, microaddress}, 32'h10);
        step();
        check("s2_call",   {24'd0, microaddress}, 32'h40);
        step();
        check("s2_ret",    {24'd0, microaddress}, 32'h11);
        check("s2_err",    {31'd0, stack_err},    32'h0);
        step();
        check("s2_brc1_nt", {24'd0, microaddress}, 32'h12);
        step();
        check("s2_brc0_t", {24'd0, microaddress}, 32'h30);
        check("s2_halted", {31'd0, halted},       32'h1);

        // Scenario 3: stack overflow on the fifth nested call, then underflow.
        rst = 1'b1;
        wr(8'h00, mk(12'h000, JMP,  8'h50));
        wr(8'h50, mk(12'h000, CALL, 8'h60));
        wr(8'h60, mk(12'h000, CALL, 8'h70));
        wr(8'h70, mk(12'h000, CALL, 8'h80));
        wr(8'h80, mk(12'h000, CALL, 8'h90));
        wr(8'h90, mk(12'h000, CALL, 8'hA0));
        wr(8'h91, mk(12'h000, RET,  8'h00));
        wr(8'h81, mk(12'h000, RET,  8'h00));
        wr(8'h71, mk(12'h000, RET,  8'h00));
        wr(8'h61, mk(12'h000, RET,  8'h00));
        wr(8'h51, mk(12'h000, RET,  8'h00));
        exp_pc  = '{8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'h91, 8'h81, 8'h71, 8'h61, 8'h51, 8'h00};
        exp_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step();
            check($sformatf("s3_pc%0d", i),  {24'd0, microaddress}, {24'd0, exp_pc[i]});
            check($sformatf("s3_err%0d", i), {31'd0, stack_err},    {31'd0, exp_err[i]});
        end

        // Scenario 4: halt held, released by rewriting the current word.
        rst = 1'b1;
        wr(8'h00, mk(12'h000, JMP,  8'h20));
        wr(8'h20, mk(12'h000, HALT, 8'h00));
        wr(8'h21, mk(12'h000, HALT, 8'h00));
        rst = 1'b0;
        step();
        check("s4_pc20", {24'd0, microaddress}, 32'h20);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("s4_hold%0d", i), {23'd0, halted, microaddress}, 32'h120);
        end
        wr(8'h20, mk(12'h000, CONT, 8'h00));
        check("s4_wr_pc",   {24'd0, microaddress}, 32'h20);
        check("s4_wr_halt", {31'd0, halted},       32'h0);
        step();
        check("s4_resume",  {24'd0, microaddress}, 32'h21);

        // Scenario 5a: CONT at the top address wraps to zero.
        rst = 1'b1;
        wr(8'h00, mk(12'h000, JMP,  8'hFF));
        wr(8'hFF, mk(12'h000, CONT, 8'h00));
        rst = 1'b0;
        step();
        check("s5_ff",   {24'd0, microaddress}, 32'hFF);
        step();
        check("s5_wrap", {24'd0, microaddress}, 32'h00);

        // Scenario 5b: reset during a pending return discards the stack.
        rst = 1'b1;
        wr(8'h00, mk(12'h000, JMP,  8'hD0));
        wr(8'hD0, mk(12'h000, CALL, 8'hE0));
        wr(8'hE0, mk(12'h000, RET,  8'h00));
        wr(8'hD1, mk(12'h000, HALT, 8'h00));
        rst = 1'b0;
        step();
        step();
        check("s5_inret", {24'd0, microaddress}, 32'hE0);
        rst = 1'b1;
        step();
        check("s5_rst_pc",  {24'd0, microaddress}, 32'h00);
        check("s5_rst_err", {31'd0, stack_err},    32'h0);
        wr(8'h00, mk(12'h000, JMP, 8'hE0));
        rst = 1'b0;
        step();
        check("s5_pcE0", {24'd0, microaddress}, 32'hE0);
        step();
        check("s5_empty_pc",  {24'd0, microaddress}, 32'h00);
        check("s5_empty_err", {31'd0, stack_err},    32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
